// File: rtl/multich_avg_pkg.sv
// Shared state encoding and sizing helpers for the multi-channel sample averager.
package multich_avg_pkg;

   typedef enum logic [1:0] {IDLE, DIV, DONE} avg_state_e;

   function automatic int sum_w(input int width, input int cnt_w);
      return width + cnt_w;
   endfunction

   function automatic int bits_per_cycle(input int s_w, input int div_cycles);
      return (s_w + div_cycles - 1) / div_cycles;
   endfunction

endpackage

// File: rtl/avg_seq_div.sv
// Sequential restoring divider: fixed DIV_CYCLES latency from start to done,
// retiring several quotient bits per cycle; a zero divisor yields quotient 0.
module avg_seq_div import multich_avg_pkg::*; #(
   parameter int SUM_W      = 24,
   parameter int CNT_W      = 16,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SUM_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic             done,
   output logic [SUM_W-1:0] quotient
);

   localparam int BPC = bits_per_cycle(SUM_W, DIV_CYCLES);
   localparam int NB  = BPC * DIV_CYCLES;
   localparam int CW  = $clog2(DIV_CYCLES + 1);

   // q_sh holds the dividend bits still to consume (top) and quotient bits produced (bottom).
   logic [NB-1:0]    q_sh;
   logic [NB-1:0]    q_nxt;
   logic [CNT_W:0]   rem;
   logic [CNT_W:0]   rem_nxt;
   logic [CNT_W-1:0] dvs;
   logic [CW-1:0]    cyc_left;
   logic             busy;
   logic             dvs_zero;

   always_comb begin
      rem_nxt = rem;
      q_nxt   = q_sh;
      for (int i = 0; i < BPC; i++) begin
         rem_nxt = {rem_nxt[CNT_W-1:0], q_nxt[NB-1]};
         q_nxt   = {q_nxt[NB-2:0], 1'b0};
         if (rem_nxt >= {1'b0, dvs}) begin
            rem_nxt  = rem_nxt - {1'b0, dvs};
            q_nxt[0] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_sh     <= '0;
         rem      <= '0;
         dvs      <= '0;
         dvs_zero <= 1'b0;
         cyc_left <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            q_sh     <= NB'(dividend);
            rem      <= '0;
            dvs      <= divisor;
            dvs_zero <= (divisor == '0);
            cyc_left <= CW'(DIV_CYCLES);
            busy     <= 1'b1;
         end else if (busy) begin
            q_sh     <= q_nxt;
            rem      <= rem_nxt;
            cyc_left <= cyc_left - 1'b1;
            if (cyc_left == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = dvs_zero ? '0 : SUM_W'(q_sh);

endmodule

// File: rtl/multich_sample_avg.sv
// Multi-channel sample averager: per-channel sum/count accumulators with sticky
// saturation, one shared sequential divider, and a request/result handshake.
module multich_sample_avg import multich_avg_pkg::*; #(
   parameter int WIDTH      = 8,
   parameter int NCH        = 4,
   parameter int CNT_W      = 16,
   parameter int DIV_CYCLES = 10,
   localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             dvalid,
   input  logic [CH_W-1:0]  ch_in,
   input  logic [NCH-1:0]   clr,
   input  logic             avg_req,
   input  logic [CH_W-1:0]  avg_req_ch,
   output logic             avg_ready,
   output logic             avg_valid,
   output logic [WIDTH-1:0] avg_out,
   output logic [CH_W-1:0]  avg_out_ch,
   output logic             avg_err,
   output logic [NCH-1:0]   sat,
   output avg_state_e       state_dbg
);

   localparam int               SUM_W   = sum_w(WIDTH, CNT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SUM_W-1:0] sum_r [NCH];
   logic [CNT_W-1:0] cnt_r [NCH];
   logic [NCH-1:0]   sat_r;
   avg_state_e       state;
   avg_state_e       state_n;
   logic             accept;
   logic             div_done;
   logic [SUM_W-1:0] div_quot;
   logic [CH_W-1:0]  ch_q;
   logic             err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            sum_r[c] <= '0;
            cnt_r[c] <= '0;
         end
         sat_r <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            // Clear beats a same-cycle sample to the same channel.
            if (clr[c]) begin
               sum_r[c] <= '0;
               cnt_r[c] <= '0;
               sat_r[c] <= 1'b0;
            end else if (dvalid && ch_in == CH_W'(c)) begin
               if (cnt_r[c] != CNT_MAX) begin
                  sum_r[c] <= sum_r[c] + SUM_W'(data_in);
                  cnt_r[c] <= cnt_r[c] + 1'b1;
               end
               if (cnt_r[c] >= CNT_MAX - 1'b1) sat_r[c] <= 1'b1;
            end
         end
      end
   end

   // Handshake: a request transfers on any edge where avg_req && avg_ready and the
   // channel is in range; the result appears as a single-cycle avg_valid strobe.
   assign accept = (state == IDLE) && avg_req && ({1'b0, avg_req_ch} < (CH_W + 1)'(NCH));

   // The divider latches the pre-update registers, so in-flight results are frozen.
   avg_seq_div #(
      .SUM_W      (SUM_W),
      .CNT_W      (CNT_W),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (accept),
      .dividend (sum_r[avg_req_ch]),
      .divisor  (cnt_r[avg_req_ch]),
      .done     (div_done),
      .quotient (div_quot)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = DIV;
         DIV:     if (div_done) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_q       <= '0;
         err_q      <= 1'b0;
         avg_out    <= '0;
         avg_out_ch <= '0;
         avg_err    <= 1'b0;
      end else begin
         if (accept) begin
            ch_q  <= avg_req_ch;
            err_q <= (cnt_r[avg_req_ch] == '0);
         end
         if (state == DIV && div_done) begin
            avg_out    <= WIDTH'(div_quot);
            avg_out_ch <= ch_q;
            avg_err    <= err_q;
         end
      end
   end

   assign avg_ready = (state == IDLE);
   assign avg_valid = (state == DONE);
   assign sat       = sat_r;
   assign state_dbg = state;

endmodule

// File: tb/tb_multich_sample_avg.sv
// Bench for multich_sample_avg: three builds share one stimulus stream and are
// checked every cycle against a per-build arithmetic model plus literal expectations.
module tb_multich_sample_avg;
   import multich_avg_pkg::*;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = '0;
   logic       dvalid = 1'b0;
   logic [1:0] ch_in = '0;
   logic [3:0] clr = '0;
   logic       avg_req = 1'b0;
   logic [1:0] avg_req_ch = '0;

   logic [NI-1:0]       rdy_w, vld_w, err_w;
   logic [NI-1:0][7:0]  out_w;
   logic [NI-1:0][1:0]  och_w;
   logic [NI-1:0][3:0]  sat_w;
   logic [3:0]          sat_a, sat_b;
   logic [2:0]          sat_c;
   avg_state_e          st_w [NI];

   assign sat_w = {{1'b0, sat_c}, sat_b, sat_a};

   always #5 clk = ~clk;

   multich_sample_avg #(.WIDTH(8), .NCH(4), .CNT_W(16), .DIV_CYCLES(10)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_in), .dvalid(dvalid), .ch_in(ch_in), .clr(clr),
      .avg_req(avg_req), .avg_req_ch(avg_req_ch), .avg_ready(rdy_w[0]), .avg_valid(vld_w[0]),
      .avg_out(out_w[0]), .avg_out_ch(och_w[0]), .avg_err(err_w[0]), .sat(sat_a), .state_dbg(st_w[0]));

   multich_sample_avg #(.WIDTH(8), .NCH(4), .CNT_W(16), .DIV_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_in), .dvalid(dvalid), .ch_in(ch_in), .clr(clr),
      .avg_req(avg_req), .avg_req_ch(avg_req_ch), .avg_ready(rdy_w[1]), .avg_valid(vld_w[1]),
      .avg_out(out_w[1]), .avg_out_ch(och_w[1]), .avg_err(err_w[1]), .sat(sat_b), .state_dbg(st_w[1]));

   multich_sample_avg #(.WIDTH(8), .NCH(3), .CNT_W(4), .DIV_CYCLES(3)) dut_c (
      .clk(clk), .rst(rst), .data_in(data_in), .dvalid(dvalid), .ch_in(ch_in), .clr(clr[2:0]),
      .avg_req(avg_req), .avg_req_ch(avg_req_ch), .avg_ready(rdy_w[2]), .avg_valid(vld_w[2]),
      .avg_out(out_w[2]), .avg_out_ch(och_w[2]), .avg_err(err_w[2]), .sat(sat_c), .state_dbg(st_w[2]));

   function automatic int p_nch(input int i);
      return (i == 2) ? 3 : 4;
   endfunction
   function automatic int p_cmax(input int i);
      return (i == 2) ? 15 : 65535;
   endfunction
   function automatic int p_dc(input int i);
      return (i == 0) ? 10 : ((i == 1) ? 1 : 3);
   endfunction

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input longint got, input longint expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d t=%0t", name, got, expv, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint m_sum [NI][4];
   int     m_cnt [NI][4];
   int     cyc = 0;
   int     busy_end [NI] = '{0, 0, 0};
   int     valid_edge [NI] = '{-1, -1, -1};
   int     pend_q [NI], pend_ch [NI];
   bit     pend_err [NI];
   int     exp_out [NI] = '{0, 0, 0};
   int     exp_ch [NI] = '{0, 0, 0};
   bit     exp_err [NI] = '{0, 0, 0};

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         for (int c = 0; c < 4; c++) begin
            m_sum[i][c] = 0;
            m_cnt[i][c] = 0;
         end
         busy_end[i] = 0;
         valid_edge[i] = -1;
         exp_out[i] = 0;
         exp_ch[i] = 0;
         exp_err[i] = 0;
      end
   endtask

   task automatic model_edge();
      int c;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (cyc == valid_edge[i]) begin
            exp_out[i] = pend_q[i];
            exp_ch[i]  = pend_ch[i];
            exp_err[i] = pend_err[i];
         end
         c = int'(avg_req_ch);
         if (avg_req && c < p_nch(i) && cyc >= busy_end[i]) begin
            pend_err[i]   = (m_cnt[i][c] == 0);
            pend_q[i]     = (m_cnt[i][c] == 0) ? 0 : int'((m_sum[i][c] / m_cnt[i][c]) % 256);
            pend_ch[i]    = c;
            valid_edge[i] = cyc + p_dc(i) + 1;
            busy_end[i]   = cyc + p_dc(i) + 3;
         end
         for (int k = 0; k < p_nch(i); k++) begin
            if (clr[k]) begin
               m_sum[i][k] = 0;
               m_cnt[i][k] = 0;
            end else if (dvalid && int'(ch_in) == k && m_cnt[i][k] < p_cmax(i)) begin
               m_sum[i][k] += data_in;
               m_cnt[i][k]++;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         bit er;
         er = (cyc + 1 >= busy_end[i]);
         chk($sformatf("cyc_ready[%0d]", i), rdy_w[i], er);
         chk($sformatf("cyc_state_idle[%0d]", i), (st_w[i] == IDLE), er);
         chk($sformatf("cyc_valid[%0d]", i), vld_w[i], (cyc == valid_edge[i]));
         chk($sformatf("cyc_out[%0d]", i), out_w[i], exp_out[i]);
         chk($sformatf("cyc_out_ch[%0d]", i), och_w[i], exp_ch[i]);
         chk($sformatf("cyc_err[%0d]", i), err_w[i], exp_err[i]);
         for (int k = 0; k < p_nch(i); k++)
            chk($sformatf("cyc_sat[%0d][%0d]", i, k), sat_w[i][k], (m_cnt[i][k] == p_cmax(i)));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int ch, input int v);
      dvalid = 1'b1;
      ch_in = 2'(ch);
      data_in = 8'(v);
      tick();
      dvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(&rdy_w) && n < 60) begin
         tick();
         n++;
      end
      chk("wait_idle", rdy_w, 3'b111);
   endtask

   task automatic request(input int ch);
      wait_idle();
      avg_req = 1'b1;
      avg_req_ch = 2'(ch);
      tick();
      avg_req = 1'b0;
      wait_idle();
   endtask

   task automatic clear_all();
      clr = 4'hF;
      tick();
      clr = 4'h0;
   endtask

   task automatic expect_res(input string name, input int i, input int q, input int ch, input int err);
      chk({name, "_out"}, out_w[i], q);
      chk({name, "_ch"}, och_w[i], ch);
      chk({name, "_err"}, err_w[i], err);
   endtask

   // ---------------- stimulus ----------------
   longint gsum;
   int     lat [2];

   initial begin
      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++) begin
         chk("reset_ready", rdy_w[i], 1);
         chk("reset_valid", vld_w[i], 0);
         expect_res("reset", i, 0, 0, 0);
         chk("reset_sat", sat_w[i], 0);
      end
      rst = 1'b0;
      tick();

      // averaging over 100 random samples, with latency measurement
      gsum = 0;
      for (int n = 0; n < 100; n++) begin
         int v;
         v = $urandom_range(0, 255);
         gsum += v;
         send(0, v);
      end
      repeat (3) tick();
      avg_req = 1'b1;
      avg_req_ch = 2'd0;
      tick();
      avg_req = 1'b0;
      lat[0] = 0;
      lat[1] = 0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         for (int i = 0; i < 2; i++)
            if (vld_w[i] && lat[i] == 0) lat[i] = n;
      end
      chk("lat_div10", lat[0], 11);
      chk("lat_div1", lat[1], 2);
      chk("avg_div10", out_w[0], gsum / 100);
      chk("avg_div1", out_w[1], gsum / 100);

      // multi-channel back-to-back
      clear_all();
      send(0, 10); send(0, 20); send(0, 30); send(0, 40);
      send(1, 255); send(1, 255); send(1, 255);
      send(2, 1); send(2, 2);
      request(0);
      for (int i = 0; i < NI; i++) expect_res("mc_ch0", i, 25, 0, 0);
      request(1);
      for (int i = 0; i < NI; i++) expect_res("mc_ch1", i, 255, 1, 0);
      request(2);
      for (int i = 0; i < NI; i++) expect_res("mc_ch2", i, 1, 2, 0);

      // empty channel on 4-channel builds, out-of-range on the 3-channel build
      avg_req = 1'b1;
      avg_req_ch = 2'd3;
      tick();
      avg_req = 1'b0;
      chk("bad_ch_ready_held", rdy_w[2], 1);
      wait_idle();
      expect_res("empty_a", 0, 0, 3, 1);
      expect_res("empty_b", 1, 0, 3, 1);
      expect_res("bad_ch_hold_c", 2, 1, 2, 0);

      // saturation on the 4-bit counter build
      clear_all();
      for (int n = 1; n <= 20; n++) begin
         send(1, 7);
         if (n == 14) chk("sat_after14", sat_c[1], 0);
         if (n == 15) chk("sat_after15", sat_c[1], 1);
      end
      request(1);
      for (int i = 0; i < NI; i++) expect_res("sat_avg", i, 7, 1, 0);
      clr = 4'b0010;
      tick();
      clr = 4'h0;
      chk("sat_cleared", sat_c[1], 0);
      request(1);
      for (int i = 0; i < NI; i++) expect_res("sat_clr_empty", i, 0, 1, 1);

      // same-cycle sample and request, then clear racing a sample
      clear_all();
      send(0, 100);
      send(0, 100);
      wait_idle();
      dvalid = 1'b1; ch_in = 2'd0; data_in = 8'd40;
      avg_req = 1'b1; avg_req_ch = 2'd0;
      tick();
      dvalid = 1'b0;
      avg_req = 1'b0;
      wait_idle();
      for (int i = 0; i < NI; i++) expect_res("snap_excl", i, 100, 0, 0);
      request(0);
      for (int i = 0; i < NI; i++) expect_res("snap_next", i, 80, 0, 0);
      clr = 4'b0001;
      dvalid = 1'b1; ch_in = 2'd0; data_in = 8'd50;
      tick();
      clr = 4'h0;
      dvalid = 1'b0;
      request(0);
      for (int i = 0; i < NI; i++) expect_res("clr_wins", i, 0, 0, 1);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         dvalid     = 1'($urandom_range(0, 1));
         ch_in      = 2'($urandom_range(0, 3));
         data_in    = 8'($urandom_range(0, 255));
         clr        = ($urandom_range(0, 40) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         avg_req    = ($urandom_range(0, 3) == 0);
         avg_req_ch = 2'($urandom_range(0, 3));
         tick();
      end
      dvalid = 1'b0;
      clr = 4'h0;
      avg_req = 1'b0;
      wait_idle();

      // reset in the middle of a division
      clear_all();
      send(0, 50);
      send(0, 50);
      wait_idle();
      avg_req = 1'b1;
      avg_req_ch = 2'd0;
      tick();
      avg_req = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int n = 0; n < 15; n++) begin
         tick();
         chk("post_rst_no_valid", vld_w[0], 0);
      end
      for (int i = 0; i < NI; i++) begin
         chk("post_rst_ready", rdy_w[i], 1);
         expect_res("post_rst", i, 0, 0, 0);
         chk("post_rst_sat", sat_w[i], 0);
      end
      request(0);
      for (int i = 0; i < NI; i++) expect_res("post_rst_empty", i, 0, 0, 1);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multich_sample_avg.md
Name: multich_sample_avg

Overview:
- Next-generation sample averager with NCH independent channels.
- Each channel has its own sum and count accumulators; all channels share one multicycle divider.
- Divider latency is set by DIV_CYCLES.
- Averages are produced on request through a ready/valid handshake, with sticky per-channel saturation and an empty-channel error flag.
- Sits between a sample source (ADC/stat front-end) and a register or stream consumer.

Parameters:
- WIDTH, 8, sample and average width.
- NCH, 4, number of channels (>=1).
- CNT_W, 16, per-channel sample counter width; sum width is SUM_W = WIDTH+CNT_W.
- DIV_CYCLES, 10, divider cycle count, legal range 1..SUM_W; divider retires ceil(SUM_W/DIV_CYCLES) quotient bits per cycle.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset.
- data_in, input, WIDTH, sample value, unsigned.
- dvalid, input, 1, sample strobe.
- ch_in, input, CH_W=max(1,$clog2(NCH)), channel of the current sample.
- clr, input, NCH, per-channel synchronous clear of sum, count and sat.
- avg_req, input, 1, average request.
- avg_req_ch, input, CH_W, channel requested.
- avg_ready, output, 1, divider idle; a request is accepted when avg_req && avg_ready.
- avg_valid, output, 1, one-cycle result strobe.
- avg_out, output, WIDTH, floor(sum/count).
- avg_out_ch, output, CH_W, channel of avg_out.
- avg_err, output, 1, count was 0 at snapshot; valid with avg_valid.
- sat, output, NCH, sticky count-saturated flags.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst is high:
  - all sums, counts and sat are 0;
  - avg_valid=0, avg_out=0, avg_out_ch=0, avg_err=0;
  - FSM is in IDLE, so avg_ready=1.
- Accumulate: on a clk edge with dvalid=1, channel ch_in does sum+=data_in and count+=1.
  - ch_in>=NCH: sample is ignored.
  - Sum cannot overflow (SUM_W bits).
- Saturation: when count==2^CNT_W-1, further samples to that channel are dropped and sat[ch] is set.
  - sat[ch] stays set until clr[ch] or rst.
- Clear: clr[ch]=1 zeroes that channel's sum, count and sat on the next edge.
  - Same-cycle dvalid to the same channel: clear wins and the sample is discarded.
  - Other channels are unaffected.
- FSM states: IDLE, DIV, DONE.
  - IDLE: avg_ready=1. On avg_req with avg_req_ch<NCH, snapshot sum/count of that channel and go to DIV. An out-of-range channel is ignored (no accept).
  - DIV: avg_ready=0. Runs DIV_CYCLES cycles, then goes to DONE.
  - DONE: avg_valid=1 for exactly one cycle; avg_out, avg_out_ch and avg_err are updated in the same cycle. Next state IDLE.
- Latency: avg_valid is high in the cycle beginning DIV_CYCLES+1 edges after the accepting edge. avg_ready returns the cycle after avg_valid.
- Snapshot:
  - Taken from pre-update register values, so a same-cycle sample to the requested channel is excluded from the result.
  - Later samples, clr or saturation on that channel never alter an in-flight result.
- Arithmetic: quotient truncates toward zero. Quotient always fits WIDTH bits (mean <= max sample); upper quotient bits are discarded.
- Zero count: avg_out=0, avg_err=1, same latency.
- Output hold: avg_out, avg_out_ch and avg_err hold between results; avg_err clears on the next non-error result.
- Reset mid-division: the operation is aborted and no avg_valid is produced; all state returns to reset values.
- Sampling continues on every channel during division.

Decomposition:
- Package multich_avg_pkg holds:
  - the avg_state_e enum (IDLE/DIV/DONE);
  - functions sum_w(WIDTH, CNT_W) and bits_per_cycle(SUM_W, DIV_CYCLES).
- Sub-module avg_seq_div: parametrised sequential restoring divider.
  - Inputs: start, dividend[SUM_W], divisor[CNT_W].
  - Outputs: done, quotient[SUM_W].
  - Fixed DIV_CYCLES latency; divisor 0 yields quotient 0.
- Top level holds the accumulator arrays, clear/saturation logic, FSM and output registers.

Test Plan:
- Averaging check: 100 random WIDTH=8 samples on ch0, then idle, then request ch0 on two instances (DIV_CYCLES=1 and DIV_CYCLES=10) -> both avg_out equal the golden sum/count; latencies 2 and 11 edges respectively.
- Multi-channel: ch0 gets 10,20,30,40, ch1 gets 255,255,255, ch2 gets 1,2; request ch0, ch1, ch2 back-to-back honouring avg_ready -> results 25/ch0, 255/ch1, 1/ch2; avg_err=0 on all.
- Empty and invalid channels: request ch3 with no samples -> avg_out=0, avg_err=1. Request avg_req_ch=NCH (non-power-of-2 NCH build) -> not accepted, avg_ready stays 1.
- Saturation (CNT_W=4): 20 samples of 7 on ch1 -> sat[1]=1 after the 15th, count 15, average 7. clr[1] -> sat[1]=0, next request gives avg_err=1.
- Simultaneous events:
  - ch0 holds {100,100}; dvalid=1 with data 40 to ch0 in the same cycle as an accepted ch0 request -> result 100. A subsequent request -> 80.
  - clr[0] and dvalid to ch0 in the same cycle -> count stays 0.
- Reset mid-DIV (DIV_CYCLES=10): assert rst 5 cycles after accept -> no avg_valid; avg_ready=1; all outputs, sat and accumulators 0 after release.
